// File: rtl/coproc_scheduler.sv
// rtl/coproc_scheduler.sv - job sequencer for the matrix processor: issues (row, col) tiles, owns the memory grant, writes status.
// Optional tile watchdog enabled by defining SCHED_WATCHDOG_EN.
module coproc_scheduler #(
  parameter int cell_width      = 32,
  parameter int index_width     = 8,
  parameter int width           = 96,
  parameter int memory_size_log = 8
`ifdef SCHED_WATCHDOG_EN
  , parameter int watchdog_limit = 1024
`endif
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_start,
  input  logic [cell_width-1:0]      in_config,
  input  logic                       in_index_ack,
  input  logic                       in_result_ready,
  input  logic                       in_proc_mem_read_en,
  input  logic                       in_proc_mem_write_en,
  input  logic [memory_size_log-1:0] in_proc_mem_address,
  input  logic [width-1:0]           in_proc_mem_data,
  output logic                       out_grant,
  output logic [index_width-1:0]     out_row_index,
  output logic [index_width-1:0]     out_col_index,
  output logic                       out_index_ready,
  output logic [index_width-1:0]     out_mu,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [memory_size_log-1:0] out_mem_address,
  output logic [width-1:0]           out_mem_data,
  output logic [cell_width-1:0]      out_status,
  output logic                       out_write_status_en,
  output logic                       out_busy,
  output logic                       out_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_RELEASE, S_NEXT, S_FINISH
  } state_t;

  localparam logic [index_width-1:0] one_idx = 1;

  state_t                 state_q, state_d;
  logic [index_width-1:0] mu_q, mu_d, gamma_q, gamma_d, lambda_q, lambda_d;
  logic [index_width-1:0] i_q, i_d, j_q, j_d;
  logic [15:0]            tiles_q, tiles_d;
  logic                   empty_q, empty_d, timeout_q, timeout_d;

  logic                   grant_q, grant_d, index_ready_q, index_ready_d;
  logic [index_width-1:0] row_q, row_d, col_q, col_d;
  logic [cell_width-1:0]  status_q, status_d;
  logic                   wstat_q, wstat_d, busy_q, busy_d, done_q, done_d;

  logic last_col, last_row;
  assign last_col = (j_q == gamma_q - one_idx);
  assign last_row = (i_q == lambda_q - one_idx);

`ifdef SCHED_WATCHDOG_EN
  logic [15:0] wdog_q, wdog_d;
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) wdog_q <= '0;
    else           wdog_q <= wdog_d;
  end
`endif

  // Config, counters and outputs are all registered; outputs lag the state by one cycle.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q       <= S_IDLE;
      mu_q          <= '0;
      gamma_q       <= '0;
      lambda_q      <= '0;
      i_q           <= '0;
      j_q           <= '0;
      tiles_q       <= '0;
      empty_q       <= 1'b0;
      timeout_q     <= 1'b0;
      grant_q       <= 1'b0;
      index_ready_q <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      status_q      <= '0;
      wstat_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mu_q          <= mu_d;
      gamma_q       <= gamma_d;
      lambda_q      <= lambda_d;
      i_q           <= i_d;
      j_q           <= j_d;
      tiles_q       <= tiles_d;
      empty_q       <= empty_d;
      timeout_q     <= timeout_d;
      grant_q       <= grant_d;
      index_ready_q <= index_ready_d;
      row_q         <= row_d;
      col_q         <= col_d;
      status_q      <= status_d;
      wstat_q       <= wstat_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mu_d      = mu_q;
    gamma_d   = gamma_q;
    lambda_d  = lambda_q;
    i_d       = i_q;
    j_d       = j_q;
    tiles_d   = tiles_q;
    empty_d   = empty_q;
    timeout_d = timeout_q;
`ifdef SCHED_WATCHDOG_EN
    wdog_d    = wdog_q;
`endif
    case (state_q)
      S_IDLE: if (in_start) state_d = S_LOAD;
      S_LOAD: begin
        mu_d      = in_config[16 +: index_width];
        gamma_d   = in_config[8 +: index_width];
        lambda_d  = in_config[0 +: index_width];
        i_d       = '0;
        j_d       = '0;
        tiles_d   = '0;
        timeout_d = 1'b0;
        empty_d   = (in_config[8 +: index_width] == '0) || (in_config[0 +: index_width] == '0);
        state_d   = empty_d ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
`ifdef SCHED_WATCHDOG_EN
        wdog_d  = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_result_ready) begin
          tiles_d = tiles_q + 16'd1;
          state_d = S_RELEASE;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (wdog_q == 16'(watchdog_limit - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      S_RELEASE: if (!in_result_ready) state_d = S_NEXT;
      S_NEXT: begin
        if (last_col && last_row) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_ISSUE;
          if (last_col) begin
            j_d = '0;
            i_d = i_q + one_idx;
          end else begin
            j_d = j_q + one_idx;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d       = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                    (state_q == S_RELEASE) || (state_q == S_NEXT);
    index_ready_d = (state_q == S_ISSUE) || (state_q == S_WAIT);
    row_d         = index_ready_d ? i_q : row_q;
    col_d         = index_ready_d ? j_q : col_q;
    wstat_d       = (state_q == S_FINISH);
    done_d        = (state_q == S_FINISH);
    busy_d        = (state_q != S_IDLE);
    status_d      = status_q;
    if (state_q == S_LOAD) status_d = '0;
    if (state_q == S_FINISH) begin
      status_d                 = '0;
      status_d[cell_width-1]   = 1'b1;
      status_d[cell_width-2]   = empty_q;
      status_d[cell_width-3]   = timeout_q;
      status_d[15:0]           = tiles_q;
    end
  end

  assign out_grant           = grant_q;
  assign out_index_ready     = index_ready_q;
  assign out_row_index       = row_q;
  assign out_col_index       = col_q;
  assign out_mu              = mu_q;
  assign out_status          = status_q;
  assign out_write_status_en = wstat_q;
  assign out_busy            = busy_q;
  assign out_done            = done_q;

  // Write beats read when the processor raises both.
  assign out_mem_write_en = grant_q & in_proc_mem_write_en;
  assign out_mem_read_en  = grant_q & in_proc_mem_read_en & ~in_proc_mem_write_en;
  assign out_mem_address  = grant_q ? in_proc_mem_address : '0;
  assign out_mem_data     = grant_q ? in_proc_mem_data : '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, in_index_ack, in_config[cell_width-1:24]};
endmodule

// File: tb/tb_coproc_scheduler.sv
// tb/tb_coproc_scheduler.sv - self-checking bench for coproc_scheduler (define SCHED_WATCHDOG_EN for the timeout case).
module tb_coproc_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [31:0] in_config = '0;
  logic        in_index_ack = 1'b0;
  logic        in_result_ready = 1'b0;
  logic        p_rd = 1'b0, p_wr = 1'b0;
  logic [7:0]  p_addr = '0;
  logic [95:0] p_data = '0;
  logic        out_grant, out_index_ready, out_mem_read_en, out_mem_write_en;
  logic        out_write_status_en, out_busy, out_done;
  logic [7:0]  out_row_index, out_col_index, out_mu, out_mem_address;
  logic [95:0] out_mem_data;
  logic [31:0] out_status;

  always #5 clk = ~clk;

  coproc_scheduler #(
    .cell_width(32), .index_width(8), .width(96), .memory_size_log(8)
`ifdef SCHED_WATCHDOG_EN
    , .watchdog_limit(16)
`endif
  ) dut (
    .in_clk(clk), .in_reset(rst_n), .in_start(in_start), .in_config(in_config),
    .in_index_ack(in_index_ack), .in_result_ready(in_result_ready),
    .in_proc_mem_read_en(p_rd), .in_proc_mem_write_en(p_wr),
    .in_proc_mem_address(p_addr), .in_proc_mem_data(p_data),
    .out_grant(out_grant), .out_row_index(out_row_index), .out_col_index(out_col_index),
    .out_index_ready(out_index_ready), .out_mu(out_mu),
    .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
    .out_mem_address(out_mem_address), .out_mem_data(out_mem_data),
    .out_status(out_status), .out_write_status_en(out_write_status_en),
    .out_busy(out_busy), .out_done(out_done)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, out_grant, 0);
    chk({tag, "_index_ready"}, out_index_ready, 0);
    chk({tag, "_indices"}, {out_row_index, out_col_index, out_mu}, 0);
    chk({tag, "_mem"}, {out_mem_read_en, out_mem_write_en, out_mem_address, out_mem_data}, 0);
    chk({tag, "_status"}, out_status, 0);
    chk({tag, "_strobes"}, {out_write_status_en, out_busy, out_done}, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one job with a processor model that pulses result_ready 5 cycles after each index_ready rise.
  task automatic run_job(input logic [31:0] cfg, input bit poke, input bit stuck,
                         input int abort_tile, input logic [31:0] exp_status, input int exp_tiles);
    int gamma = int'(cfg[15:8]);
    int lambda = int'(cfg[7:0]);
    int rises = 0, dones = 0, cyc = 0, cd = 0, first_rise = -1, done_cyc = -1;
    logic prev_ir = 1'b0;
    logic [15:0] e;
    exp_q.delete();
    for (int i = 0; i < lambda; i++)
      for (int j = 0; j < gamma; j++)
        exp_q.push_back({i[7:0], j[7:0]});
    in_config = cfg;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    cyc = 1;
    while (cyc < 400 && !(dones > 0 && cyc > done_cyc + 3)) begin
      tick();
      cyc++;
      in_result_ready = 1'b0;
      in_start = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !stuck) in_result_ready = 1'b1;
      end
      if (out_index_ready && !prev_ir) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        cd = 5;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("tile%0d_row", rises), out_row_index, e[15:8]);
          chk($sformatf("tile%0d_col", rises), out_col_index, e[7:0]);
        end else begin
          chk("extra_tile", rises, exp_tiles);
        end
        chk("tile_grant", out_grant, 1);
        chk("tile_mu", out_mu, cfg[23:16]);
        if (abort_tile == rises) begin
          rst_n = 1'b0;
          #1;
          chk_all_zero("abort");
          tick();
          rst_n = 1'b1;
          return;
        end
        if (poke && rises == 2) in_start = 1'b1;
      end
      if (out_done) begin
        dones++;
        done_cyc = cyc;
        chk("done_status", out_status, exp_status);
        chk("done_wstat", out_write_status_en, 1);
        chk("done_grant", out_grant, 0);
      end
      prev_ir = out_index_ready;
    end
    chk("done_count", dones, 1);
    chk("tile_count", rises, exp_tiles);
    if (exp_status[30]) chk("empty_latency", done_cyc, 3);
    else chk("first_issue_latency", first_rise, 3);
    if (stuck) chk("wdog_latency", done_cyc, 20);
    chk("status_hold", out_status, exp_status);
    chk("idle_busy", out_busy, 0);
  endtask

  typedef struct {
    logic [31:0] cfg;
    bit          poke;
    logic [31:0] exp_status;
    int          exp_tiles;
  } job_vec_t;

  typedef struct {
    logic rd, wr;
    logic [7:0] addr;
    logic [95:0] data;
    logic exp_rd, exp_wr;
  } mem_vec_t;

  job_vec_t jobs[7];
  mem_vec_t mems[4];

  initial begin
    jobs[0] = '{32'h0003_0202, 1'b0, 32'h8000_0004, 4};
    jobs[1] = '{32'h0003_0200, 1'b0, 32'hC000_0000, 0};
    jobs[2] = '{32'h0003_0002, 1'b0, 32'hC000_0000, 0};
    jobs[3] = '{32'h0007_0103, 1'b0, 32'h8000_0003, 3};
    jobs[4] = '{32'h0001_0301, 1'b0, 32'h8000_0003, 3};
    jobs[5] = '{32'h0003_0202, 1'b1, 32'h8000_0004, 4};
    jobs[6] = '{32'hFF05_0000, 1'b0, 32'hC000_0000, 0};
    mems[0] = '{1'b0, 1'b1, 8'h09, {12{8'hA5}}, 1'b0, 1'b1};
    mems[1] = '{1'b1, 1'b0, 8'h33, 96'h1234_5678_9ABC_DEF0_0F1E_2D3C, 1'b1, 1'b0};
    mems[2] = '{1'b1, 1'b1, 8'hFF, {3{32'hDEAD_BEEF}}, 1'b0, 1'b1};
    mems[3] = '{1'b0, 1'b0, 8'h00, 96'h1, 1'b0, 1'b0};

    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    foreach (jobs[k]) run_job(jobs[k].cfg, jobs[k].poke, 1'b0, 0, jobs[k].exp_status, jobs[k].exp_tiles);

    // Memory mux: blocked while idle, forwarded while granted.
    foreach (mems[k]) begin
      {p_rd, p_wr, p_addr, p_data} = {mems[k].rd, mems[k].wr, mems[k].addr, mems[k].data};
      #1;
      chk($sformatf("mem%0d_idle", k), {out_mem_read_en, out_mem_write_en, out_mem_address, out_mem_data}, 0);
    end
    in_config = 32'h0001_0101;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    for (int c = 0; c < 20 && !out_grant; c++) tick();
    chk("grant_seen", out_grant, 1);
    foreach (mems[k]) begin
      {p_rd, p_wr, p_addr, p_data} = {mems[k].rd, mems[k].wr, mems[k].addr, mems[k].data};
      #1;
      chk($sformatf("mem%0d_granted", k),
          {out_mem_read_en, out_mem_write_en, out_mem_address, out_mem_data},
          {mems[k].exp_rd, mems[k].exp_wr, mems[k].addr, mems[k].data});
    end
    tick();
    in_result_ready = 1'b1;
    tick();
    in_result_ready = 1'b0;
    for (int c = 0; c < 20 && !out_done; c++) tick();
    chk("mux_job_status", out_status, 32'h8000_0001);
    tick();
    tick();

    // Reset during WAIT of tile (0,1), with the processor driving a write.
    {p_rd, p_wr, p_addr, p_data} = {1'b0, 1'b1, 8'h09, {12{8'hA5}}};
    run_job(32'h0003_0202, 1'b0, 1'b0, 2, 32'h0, 0);
    {p_rd, p_wr, p_addr, p_data} = '0;
    tick();
    run_job(jobs[0].cfg, 1'b0, 1'b0, 0, jobs[0].exp_status, jobs[0].exp_tiles);

`ifdef SCHED_WATCHDOG_EN
    run_job(32'h0003_0202, 1'b0, 1'b1, 0, 32'hA000_0000, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
